// File: rtl/fc_layer_sequencer.sv
// Sequencer for a fully connected layer: streams one frame of H input words to the
// neuron array with shared weight addressing, then triggers the bias add and holds the result.
module fc_layer_sequencer #(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    parameter int RAM_ADDRESS_BITS      = $clog2(PREVIOUS_LAYER_HEIGHT + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic signed [WORD_SIZE-1:0]        data_i,
    output logic signed [WORD_SIZE-1:0]        data_o,
    output logic        [RAM_ADDRESS_BITS-1:0] w_addr_o,
    output logic                               sum_en_o,
    output logic                               add_bias_o,
    output logic                               valid_o,
    input  logic                               ready_i
);

    typedef enum logic [1:0] {StCollect, StBias, StApply, StDone} state_e;

    localparam logic [RAM_ADDRESS_BITS-1:0] LastIdx  = RAM_ADDRESS_BITS'(PREVIOUS_LAYER_HEIGHT - 1);
    localparam logic [RAM_ADDRESS_BITS-1:0] BiasAddr = RAM_ADDRESS_BITS'(PREVIOUS_LAYER_HEIGHT);

    state_e                      state_q;
    logic [RAM_ADDRESS_BITS-1:0] cnt_q;
    logic                        fire;

    assign ready_o  = (state_q == StCollect);
    assign fire     = valid_i && ready_o;
    // The bias lives one slot past the last weight in every neuron's ROM.
    assign w_addr_o = ready_o ? cnt_q : BiasAddr;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StCollect;
            cnt_q      <= '0;
            data_o     <= '0;
            sum_en_o   <= 1'b0;
            add_bias_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            // MAC enable trails the fire by one cycle to line up with the ROM read.
            sum_en_o   <= fire;
            add_bias_o <= 1'b0;
            if (fire) begin
                data_o <= data_i;
            end
            unique case (state_q)
                StCollect: begin
                    if (fire) begin
                        if (cnt_q == LastIdx) begin
                            cnt_q   <= '0;
                            state_q <= StBias;
                        end else begin
                            cnt_q <= cnt_q + RAM_ADDRESS_BITS'(1);
                        end
                    end
                end
                StBias: begin
                    add_bias_o <= 1'b1;
                    state_q    <= StApply;
                end
                StApply: begin
                    valid_o <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state_q <= StCollect;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: vector table for the main frame flow,
// hand sequences for result hold, mid-frame reset and the single-word layer.
module tb_fc_layer_sequencer;

    typedef struct {
        bit          v;
        bit          ri;
        logic [15:0] d;
        bit          e_rdy;
        int          e_addr;
        bit          e_sum;
        bit          e_bias;
        bit          e_vld;
        logic [15:0] e_data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // H = 4 instance
    logic               reset_i = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
    logic signed [15:0] data_i = '0, data_o;
    logic        [2:0]  w_addr_o;
    logic               ready_o, sum_en_o, add_bias_o, valid_o;

    // H = 1 instance
    logic               rst1 = 1'b1, valid1 = 1'b0, rdy_in1 = 1'b0;
    logic signed [15:0] data_i1 = 16'sd51, data_o1;
    logic        [0:0]  w_addr1;
    logic               ready1, sum_en1, add_bias1, valid_o1;

    fc_layer_sequencer #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .data_o(data_o), .w_addr_o(w_addr_o), .sum_en_o(sum_en_o),
        .add_bias_o(add_bias_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    fc_layer_sequencer #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst1), .valid_i(valid1), .ready_o(ready1),
        .data_i(data_i1), .data_o(data_o1), .w_addr_o(w_addr1), .sum_en_o(sum_en1),
        .add_bias_o(add_bias1), .valid_o(valid_o1), .ready_i(rdy_in1)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input bit v, input bit ri, input logic [15:0] d, input bit er,
                           input int ea, input bit es, input bit eb, input bit ev,
                           input logic [15:0] ed);
        vec_t r;
        r.v = v; r.ri = ri; r.d = d; r.e_rdy = er; r.e_addr = ea;
        r.e_sum = es; r.e_bias = eb; r.e_vld = ev; r.e_data = ed;
        vq.push_back(r);
    endtask

    task automatic invariants();
        chk("sum_and_bias_exclusive", {31'd0, sum_en_o && add_bias_o}, 32'd0);
        chk("ready_only_collect", {31'd0, ready_o && (valid_o || add_bias_o)}, 32'd0);
    endtask

    task automatic step(input bit v, input bit ri, input logic [15:0] d);
        @(posedge clk);
        #1;
        valid_i = v; ready_i = ri; data_i = d;
        @(negedge clk);
    endtask

    int bias_pulses;

    initial begin
        // Vectors: each row = inputs this cycle, expected outputs seen in the same cycle.
        // Frame 1..4 on consecutive cycles.
        add_vec(1, 0, 16'd1,  1, 0, 0, 0, 0, 16'd0);
        add_vec(1, 0, 16'd2,  1, 1, 1, 0, 0, 16'd1);
        add_vec(1, 0, 16'd3,  1, 2, 1, 0, 0, 16'd2);
        add_vec(1, 0, 16'd4,  1, 3, 1, 0, 0, 16'd3);
        add_vec(1, 0, 16'd99, 0, 4, 1, 0, 0, 16'd4);
        add_vec(1, 0, 16'd98, 0, 4, 0, 1, 0, 16'd4);
        add_vec(1, 0, 16'd97, 0, 4, 0, 0, 1, 16'd4);
        add_vec(0, 1, 16'd0,  0, 4, 0, 0, 1, 16'd4);
        add_vec(0, 0, 16'd0,  1, 0, 0, 0, 0, 16'd4);
        // Alternating valid: gaps hold address and data, MAC pulses once per fire.
        add_vec(1, 0, 16'd10,   1, 0, 0, 0, 0, 16'd4);
        add_vec(0, 0, 16'd11,   1, 1, 1, 0, 0, 16'd10);
        add_vec(1, 0, 16'd12,   1, 1, 0, 0, 0, 16'd10);
        add_vec(0, 0, 16'd13,   1, 2, 1, 0, 0, 16'd12);
        add_vec(1, 0, 16'hFFFB, 1, 2, 0, 0, 0, 16'd12);
        add_vec(0, 0, 16'd14,   1, 3, 1, 0, 0, 16'hFFFB);
        add_vec(1, 0, 16'd7,    1, 3, 0, 0, 0, 16'hFFFB);
        add_vec(0, 0, 16'd15,   0, 4, 1, 0, 0, 16'd7);
        add_vec(1, 0, 16'd16,   0, 4, 0, 1, 0, 16'd7);
        add_vec(1, 0, 16'd17,   0, 4, 0, 0, 1, 16'd7);

        // Reset state
        #3;
        chk("reset_data", {16'd0, data_o}, 32'd0);
        chk("reset_addr", {29'd0, w_addr_o}, 32'd0);
        chk("reset_sum", {31'd0, sum_en_o}, 32'd0);
        chk("reset_bias", {31'd0, add_bias_o}, 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, ready_o}, 32'd1);

        foreach (vq[i]) begin
            step(vq[i].v, vq[i].ri, vq[i].d);
            chk($sformatf("row%0d_ready", i), {31'd0, ready_o}, {31'd0, vq[i].e_rdy});
            chk($sformatf("row%0d_addr", i), {29'd0, w_addr_o}, 32'(vq[i].e_addr));
            chk($sformatf("row%0d_sum_en", i), {31'd0, sum_en_o}, {31'd0, vq[i].e_sum});
            chk($sformatf("row%0d_add_bias", i), {31'd0, add_bias_o}, {31'd0, vq[i].e_bias});
            chk($sformatf("row%0d_valid", i), {31'd0, valid_o}, {31'd0, vq[i].e_vld});
            chk($sformatf("row%0d_data", i), {16'd0, data_o}, {16'd0, vq[i].e_data});
            invariants();
        end

        // Result held in DONE while downstream stalls and upstream keeps offering words.
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 16'(100 + k));
            chk("hold_valid", {31'd0, valid_o}, 32'd1);
            chk("hold_ready", {31'd0, ready_o}, 32'd0);
            chk("hold_sum", {31'd0, sum_en_o}, 32'd0);
            chk("hold_data", {16'd0, data_o}, 32'd7);
        end
        step(1, 1, 16'd200);
        chk("handshake_valid", {31'd0, valid_o}, 32'd1);
        step(0, 0, 16'd0);
        chk("release_ready", {31'd0, ready_o}, 32'd1);
        chk("release_addr", {29'd0, w_addr_o}, 32'd0);
        chk("release_valid", {31'd0, valid_o}, 32'd0);
        chk("release_sum", {31'd0, sum_en_o}, 32'd0);

        // Reset after two words of a frame discards it.
        step(1, 0, 16'd1);
        step(1, 0, 16'd2);
        step(0, 0, 16'd0);
        chk("pre_reset_sum", {31'd0, sum_en_o}, 32'd1);
        chk("pre_reset_data", {16'd0, data_o}, 32'd2);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_reset_data", {16'd0, data_o}, 32'd0);
        chk("async_reset_sum", {31'd0, sum_en_o}, 32'd0);
        chk("async_reset_addr", {29'd0, w_addr_o}, 32'd0);
        chk("async_reset_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 16'(5 + k));
            chk($sformatf("refill_addr%0d", k), {29'd0, w_addr_o}, 32'(k));
            chk($sformatf("refill_ready%0d", k), {31'd0, ready_o}, 32'd1);
        end
        bias_pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 16'd0);
            if (add_bias_o) bias_pulses++;
            invariants();
        end
        chk("refill_bias_pulses", 32'(bias_pulses), 32'd1);
        chk("refill_valid", {31'd0, valid_o}, 32'd1);
        chk("refill_data", {16'd0, data_o}, 32'd8);

        // H = 1 with valid and ready tied high: four-cycle repeating pattern.
        valid1 = 1'b1;
        rdy_in1 = 1'b1;
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("h1_ready%0d", k), {31'd0, ready1}, {31'd0, (k % 4) == 0});
            chk($sformatf("h1_sum%0d", k), {31'd0, sum_en1}, {31'd0, (k % 4) == 1});
            chk($sformatf("h1_bias%0d", k), {31'd0, add_bias1}, {31'd0, (k % 4) == 2});
            chk($sformatf("h1_valid%0d", k), {31'd0, valid_o1}, {31'd0, (k % 4) == 3});
            chk($sformatf("h1_addr%0d", k), {31'd0, w_addr1}, {31'd0, (k % 4) != 0});
            chk($sformatf("h1_excl%0d", k), {31'd0, sum_en1 && add_bias1}, 32'd0);
            @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer_sequencer.md
FC_LAYER_SEQUENCER -- requirements
Module: fc_layer_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of the data words streamed to the neuron array.
REQ-002 Parameter PREVIOUS_LAYER_HEIGHT, default 4, number of input words per frame (H).
REQ-003 Parameter RAM_ADDRESS_BITS, default $clog2(PREVIOUS_LAYER_HEIGHT+1), width of the weight/bias address.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock; all state changes on rising edge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 valid_i  input  1  upstream word valid.
REQ-008 ready_o  output  1  sequencer accepts a word this cycle.
REQ-009 data_i  input  WORD_SIZE  upstream word, signed.
REQ-010 data_o  output  WORD_SIZE  registered word broadcast to every neuron data_i, signed.
REQ-011 w_addr_o  output  RAM_ADDRESS_BITS  shared weight/bias ROM address to all neurons.
REQ-012 sum_en_o  output  1  neuron multiply-accumulate enable.
REQ-013 add_bias_o  output  1  neuron bias-add strobe.
REQ-014 valid_o  output  1  neuron outputs hold a complete frame result.
REQ-015 ready_i  input  1  downstream consumed the result.

Function
REQ-016 States: COLLECT, BIAS, APPLY, DONE; counter cnt in [0, H-1].
REQ-017 ready_o = 1 only in COLLECT; 0 in BIAS, APPLY, DONE.
REQ-018 Fire = valid_i && ready_o; only a fire accepts a word.
REQ-019 In COLLECT, w_addr_o = cnt combinationally, fire or not.
REQ-020 On fire at cycle t: data_o <= data_i and sum_en_o = 1 at t+1 (one-cycle ROM read alignment).
REQ-021 No fire at cycle t: sum_en_o = 0 at t+1; data_o holds; cnt and w_addr_o hold (stall tolerated indefinitely).
REQ-022 Fire with cnt < H-1: cnt increments, stay COLLECT.
REQ-023 Fire with cnt = H-1: cnt <= 0, go to BIAS.
REQ-024 BIAS (one cycle): w_addr_o = H; sum_en_o = 1 from last word; add_bias_o = 0; always -> APPLY.
REQ-025 APPLY (one cycle): w_addr_o = H; add_bias_o = 1; sum_en_o = 0; always -> DONE.
REQ-026 DONE: valid_o = 1, w_addr_o = H, sum_en_o = add_bias_o = 0; hold until ready_i = 1.
REQ-027 DONE with ready_i = 1: -> COLLECT next cycle; valid_o = 0 and ready_o = 1 that cycle.
REQ-028 valid_i asserted during BIAS/APPLY/DONE is ignored; word is not consumed.
REQ-029 add_bias_o and sum_en_o are never both 1 in the same cycle.
REQ-030 Fixed latency: last-word fire at t -> add_bias_o at t+2 -> valid_o at t+3.
REQ-031 H = 1 legal: every fire goes directly to BIAS.
REQ-032 All outputs except ready_o and w_addr_o are registered.

Reset
REQ-033 reset_i asserted: immediately state = COLLECT, cnt = 0, data_o = 0, sum_en_o = 0, add_bias_o = 0, valid_o = 0, w_addr_o = 0, ready_o = 1 after release.
REQ-034 Reset mid-frame or in DONE discards the partial frame/result; next fire is word 0.

Verification
REQ-035 H=4, words 1,2,3,4 on consecutive cycles from t=0 -> w_addr_o 0,1,2,3 at t0-t3; sum_en_o=1 at t1-t4; w_addr_o=4 at t4; add_bias_o=1 at t5; valid_o=1 from t6.
REQ-036 H=4, valid_i toggled 1,0,1,0... -> sum_en_o pulses only cycle after each fire; w_addr_o holds during gaps; add_bias_o exactly once per frame.
REQ-037 DONE with ready_i=0 for 10 cycles, valid_i=1 throughout -> valid_o stays 1, ready_o stays 0, no sum_en_o; ready_i=1 -> next cycle ready_o=1, w_addr_o=0.
REQ-038 Reset asserted after word 2 of frame -> all outputs zero asynchronously; next frame 5,6,7,8 produces addresses 0-3 and one add_bias_o.
REQ-039 H=1, back-to-back frames with ready_i tied 1 -> pattern COLLECT, BIAS, APPLY, DONE repeats every 4 cycles; ready_o high 1 of 4 cycles.
REQ-040 Assertion over all tests: sum_en_o && add_bias_o never true; ready_o only in COLLECT.
